// File: rtl/vx_raster_be_dispatch.sv
// Raster back-end dispatcher: hands tile-stage blocks to block-evaluator lanes
// round-robin over ready lanes. A one-entry holding register sits between
// upstream and the lanes, and an end-of-batch flush stalls input until every
// lane has drained.
module vx_raster_be_dispatch #(
    parameter int NUM_BES    = 4,
    parameter int DATAW      = 64,
    parameter int PERF_CTR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATAW-1:0]      data_in,
    output logic                  ready_in,
    input  logic                  flush_in,
    output logic                  flush_done,
    output logic [NUM_BES-1:0]    be_valid,
    output logic [DATAW-1:0]      be_data,
    input  logic [NUM_BES-1:0]    be_ready,
    input  logic [NUM_BES-1:0]    be_busy,
    output logic                  busy_out,
    output logic [PERF_CTR_W-1:0] perf_blocks
);

    localparam int PTR_W = (NUM_BES > 1) ? $clog2(NUM_BES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               hold_valid;
    logic [DATAW-1:0]   hold_data;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   rr_next;
    logic               any_ready;
    logic               hold_fire;
    logic               accept;

    // Search lanes starting at rr_ptr and take the first one that is ready
    always_comb begin
        grant     = '0;
        any_ready = 1'b0;
        for (int off = 0; off < NUM_BES; off++) begin
            if (!any_ready && be_ready[(int'(rr_ptr) + off) % NUM_BES]) begin
                any_ready = 1'b1;
                grant     = PTR_W'((int'(rr_ptr) + off) % NUM_BES);
            end
        end
    end

    // Offer the held block only to the granted lane
    always_comb begin
        be_valid = '0;
        if (hold_valid && any_ready) begin
            be_valid[grant] = 1'b1;
        end
    end

    assign rr_next     = PTR_W'((int'(grant) + 1) % NUM_BES);
    assign hold_fire   = hold_valid && (|(be_valid & be_ready));
    assign ready_in    = (state == ST_RUN) && (!hold_valid || hold_fire);
    assign accept      = valid_in && ready_in;
    assign be_data     = hold_data;
    assign flush_done  = (state == ST_DONE);
    assign busy_out    = hold_valid || (|be_busy) || (state != ST_RUN);

    // Holding-register occupancy, round-robin pointer, counter and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid  <= 1'b0;
            rr_ptr      <= '0;
            perf_blocks <= '0;
            state       <= ST_RUN;
        end else begin
            state <= state_next;
            if (accept) begin
                hold_valid <= 1'b1;
            end else if (hold_fire) begin
                hold_valid <= 1'b0;
            end
            if (hold_fire) begin
                rr_ptr      <= rr_next;
                perf_blocks <= perf_blocks + 1'b1;
            end
        end
    end

    // Payload needs no reset; it is only observed while hold_valid is set
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= data_in;
        end
    end

    // Flush sequencing: stall input, wait for lanes to go idle, pulse done
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (flush_in) state_next = ST_DRAIN;
            ST_DRAIN: if (!hold_valid && (be_busy == '0)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // A second flush before the first has retired is an upstream protocol error
    a_flush_only_in_run: assert property (@(posedge clk) disable iff (reset)
        flush_in |-> (state == ST_RUN));

    a_onehot_valid: assert property (@(posedge clk) disable iff (reset)
        $onehot0(be_valid));

    a_data_stable: assert property (@(posedge clk) disable iff (reset)
        (hold_valid && !hold_fire) |=> (be_data == $past(be_data)));

endmodule

// File: tb/tb_vx_raster_be_dispatch.sv
// Testbench for vx_raster_be_dispatch: directed vector table, hand-written
// flush/reset sequences and a randomized run against a queue-based model.
module tb_vx_raster_be_dispatch;

    localparam int NUM_BES    = 4;
    localparam int DATAW      = 64;
    localparam int PERF_CTR_W = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  valid_in;
    logic [DATAW-1:0]      data_in;
    logic                  ready_in;
    logic                  flush_in;
    logic                  flush_done;
    logic [NUM_BES-1:0]    be_valid;
    logic [DATAW-1:0]      be_data;
    logic [NUM_BES-1:0]    be_ready;
    logic [NUM_BES-1:0]    be_busy;
    logic                  busy_out;
    logic [PERF_CTR_W-1:0] perf_blocks;

    vx_raster_be_dispatch #(
        .NUM_BES(NUM_BES), .DATAW(DATAW), .PERF_CTR_W(PERF_CTR_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .flush_in(flush_in), .flush_done(flush_done),
        .be_valid(be_valid), .be_data(be_data), .be_ready(be_ready),
        .be_busy(be_busy), .busy_out(busy_out), .perf_blocks(perf_blocks)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: holding register as a queue, phase 0=run 1=drain 2=done
    logic [DATAW-1:0]      m_held[$];
    int                    m_rr    = 0;
    int                    m_phase = 0;
    logic [PERF_CTR_W-1:0] m_perf  = '0;
    int                    m_lane;
    bit                    m_fire;
    bit                    m_accept_ok;

    typedef struct {
        logic             v;
        logic [DATAW-1:0] d;
        logic [3:0]       rdy;
        logic [3:0]       busy;
        logic             fl;
        logic             exp_rdy;
        logic [3:0]       exp_bev;
        logic [31:0]      exp_perf;
        logic             data_chk;
        logic [DATAW-1:0] exp_data;
    } vec_t;

    vec_t tbl[20];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [DATAW-1:0] d, input logic [3:0] rdy,
                         input logic [3:0] busy, input logic fl);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        be_ready = rdy;
        be_busy  = busy;
        flush_in = fl;
        #1;
    endtask

    task automatic check_model();
        bit held;
        logic [3:0] exp_bev;
        held   = (m_held.size() > 0);
        m_lane = -1;
        for (int off = 0; off < NUM_BES; off++) begin
            if (m_lane < 0 && be_ready[(m_rr + off) % NUM_BES])
                m_lane = (m_rr + off) % NUM_BES;
        end
        m_fire      = held && (m_lane >= 0);
        exp_bev     = m_fire ? 4'(1 << m_lane) : 4'b0000;
        m_accept_ok = (m_phase == 0) && (!held || m_fire);
        check_output("model_ready_in", 64'(ready_in), 64'(m_accept_ok));
        check_output("model_be_valid", 64'(be_valid), 64'(exp_bev));
        check_output("model_flush_done", 64'(flush_done), 64'(m_phase == 2));
        check_output("model_busy_out", 64'(busy_out),
                     64'(held || (be_busy != 0) || (m_phase != 0)));
        check_output("model_perf", 64'(perf_blocks), 64'(m_perf));
        if (held) check_output("model_be_data", be_data, m_held[0]);
    endtask

    task automatic tick();
        bit held;
        held = (m_held.size() > 0);
        @(posedge clk);
        if (m_fire) begin
            void'(m_held.pop_front());
            m_rr = (m_lane + 1) % NUM_BES;
            m_perf++;
        end
        if (valid_in && m_accept_ok) m_held.push_back(data_in);
        case (m_phase)
            0: if (flush_in) m_phase = 1;
            1: if (!held && be_busy == 0) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    task automatic apply_stimulus(input logic v, input logic [DATAW-1:0] d, input logic [3:0] rdy,
                                  input logic [3:0] busy, input logic fl);
        drive(v, d, rdy, busy, fl);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        @(posedge clk);
        m_held.delete();
        m_rr    = 0;
        m_phase = 0;
        m_perf  = '0;
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; flush_in = 1'b0;
        be_ready = '0; be_busy = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state
        drive(1'b0, '0, 4'h0, 4'h0, 1'b0);
        check_output("rst_ready_in", 64'(ready_in), 64'd1);
        check_output("rst_be_valid", 64'(be_valid), 64'd0);
        check_output("rst_perf", 64'(perf_blocks), 64'd0);
        check_output("rst_flush_done", 64'(flush_done), 64'd0);
        check_output("rst_busy_out", 64'(busy_out), 64'd0);
        check_model();
        tick();

        // Directed table: back-to-back rotation, lane skipping, full backpressure
        tbl[0]  = '{1'b1, 64'hA0, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd0, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 64'hA1, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 32'd0, 1'b1, 64'hA0};
        tbl[2]  = '{1'b1, 64'hA2, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 32'd1, 1'b1, 64'hA1};
        tbl[3]  = '{1'b1, 64'hA3, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 32'd2, 1'b1, 64'hA2};
        tbl[4]  = '{1'b0, 64'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 32'd3, 1'b1, 64'hA3};
        tbl[5]  = '{1'b0, 64'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd4, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, 64'hB0, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd4, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 64'hB1, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 32'd4, 1'b1, 64'hB0};
        tbl[8]  = '{1'b0, 64'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 32'd5, 1'b1, 64'hB1};
        tbl[9]  = '{1'b1, 64'hC0, 4'hB, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd6, 1'b0, 64'h0};
        tbl[10] = '{1'b1, 64'hC1, 4'hB, 4'h0, 1'b0, 1'b1, 4'b1000, 32'd6, 1'b1, 64'hC0};
        tbl[11] = '{1'b0, 64'h00, 4'hB, 4'h0, 1'b0, 1'b1, 4'b0001, 32'd7, 1'b1, 64'hC1};
        tbl[12] = '{1'b1, 64'hD0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd8, 1'b0, 64'h0};
        for (int i = 13; i < 18; i++)
            tbl[i] = '{1'b1, 64'hD1, 4'h0, 4'h0, 1'b0, 1'b0, 4'b0000, 32'd8, 1'b1, 64'hD0};
        tbl[18] = '{1'b0, 64'h00, 4'hB, 4'h0, 1'b0, 1'b1, 4'b0010, 32'd8, 1'b1, 64'hD0};
        tbl[19] = '{1'b0, 64'h00, 4'hF, 4'h0, 1'b0, 1'b1, 4'b0000, 32'd9, 1'b0, 64'h0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].busy, tbl[i].fl);
            check_output($sformatf("tbl%0d_ready_in", i), 64'(ready_in), 64'(tbl[i].exp_rdy));
            check_output($sformatf("tbl%0d_be_valid", i), 64'(be_valid), 64'(tbl[i].exp_bev));
            check_output($sformatf("tbl%0d_perf", i), 64'(perf_blocks), 64'(tbl[i].exp_perf));
            if (tbl[i].data_chk)
                check_output($sformatf("tbl%0d_be_data", i), be_data, tbl[i].exp_data);
            check_model();
            tick();
        end

        // Flush with lane 1 busy for 10 cycles starting at the flush cycle
        for (int c = 0; c < 15; c++) begin
            logic v;
            logic fl;
            logic [3:0] busy;
            v    = (c < 3);
            fl   = (c == 2);
            busy = (c >= 2 && c <= 11) ? 4'b0010 : 4'b0000;
            drive(v, 64'hE0 + 64'(c), 4'hF, busy, fl);
            check_output($sformatf("flush_c%0d_ready_in", c), 64'(ready_in),
                         64'((c < 3) || (c == 14)));
            check_output($sformatf("flush_c%0d_flush_done", c), 64'(flush_done), 64'(c == 13));
            check_model();
            tick();
        end

        // Empty flush: done pulse two cycles after the request
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 4'hF, 4'h0, c == 0);
            check_output($sformatf("eflush_c%0d_flush_done", c), 64'(flush_done), 64'(c == 2));
            check_output($sformatf("eflush_c%0d_ready_in", c), 64'(ready_in),
                         64'(c == 0 || c == 3));
            check_model();
            tick();
        end

        // Reset while draining with a block still held
        apply_stimulus(1'b1, 64'hF00D, 4'h0, 4'h0, 1'b1);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, 4'hF, 4'h0, 1'b0);
            if (c == 0) begin
                check_output("rstdrain_be_valid", 64'(be_valid), 64'd0);
                check_output("rstdrain_ready_in", 64'(ready_in), 64'd1);
                check_output("rstdrain_perf", 64'(perf_blocks), 64'd0);
            end
            check_output($sformatf("rstdrain_c%0d_flush_done", c), 64'(flush_done), 64'd0);
            check_model();
            tick();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic v;
            logic fl;
            logic [3:0] rdy;
            logic [3:0] busy;
            v    = ($urandom_range(0, 3) != 0);
            rdy  = 4'($urandom);
            busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            fl   = (m_phase == 0) && ($urandom_range(0, 15) == 0);
            apply_stimulus(v, {$urandom, $urandom}, rdy, busy, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
